board_reg_viewer: RTL and testbench



---
 rtl/board_reg_viewer.sv | 144 ++++++++++++++
 tb/tb_board_reg_viewer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/board_reg_viewer.sv
// Key-driven register viewer: selects a CPU register address and shows a window of its value on LEDs.
// Optional key debouncer is built when BOARD_REG_VIEWER_DEBOUNCE_EN is defined.
module board_reg_viewer #(
    parameter int LED_WIDTH       = 8,
    parameter int REG_ADDR_W      = 5,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SCAN_CYCLES     = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  keyNext,
    input  logic                  keyMode,
    input  logic                  heartbeat,
    input  logic [31:0]           regData,
    output logic [REG_ADDR_W-1:0] regAddr,
    output logic [LED_WIDTH-1:0]  led,
    output logic                  scanMode
);

    localparam int DISP_W = LED_WIDTH - 1;
    localparam int SCAN_W = $clog2(SCAN_CYCLES);
    localparam int OFF_W  = 6;

    if (DEBOUNCE_CYCLES < 1 || SCAN_CYCLES < 2) begin : g_param_check
        $error("board_reg_viewer: DEBOUNCE_CYCLES must be >= 1 and SCAN_CYCLES >= 2");
    end

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } mode_t;

    // Bit 0 carries keyNext, bit 1 carries keyMode through the front end.
    logic [1:0]            sync1_q, sync1_d;
    logic [1:0]            sync2_q, sync2_d;
    logic [1:0]            level_q, level_d;
    logic [1:0]            press;

    mode_t                 state_q, state_d;
    logic [REG_ADDR_W-1:0] addr_q, addr_d;
    logic [OFF_W-1:0]      offset_q, offset_d;
    logic [SCAN_W-1:0]     timer_q, timer_d;
    logic [LED_WIDTH-1:0]  led_q, led_d;
    logic                  scan_mode_q, scan_mode_d;

    logic [OFF_W:0]        offset_sum;
    logic [DISP_W+31:0]    data_ext;

`ifdef BOARD_REG_VIEWER_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
`endif

    // level_d is the debounced level as of this cycle; press fires on its rising edge.
    always_comb begin
        sync1_d = {keyMode, keyNext};
        sync2_d = sync1_q;
`ifdef BOARD_REG_VIEWER_DEBOUNCE_EN
        level_d  = level_q;
        db_cnt_d = '0;
        for (int k = 0; k < 2; k++) begin
            if (sync2_q[k] != level_q[k]) begin
                if (db_cnt_q[k] == DB_W'(DEBOUNCE_CYCLES)) begin
                    level_d[k] = sync2_q[k];
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + 1'b1;
                end
            end
        end
`else
        level_d = sync2_q;
`endif
        press = level_d & ~level_q;
    end

    // A keyNext press acts on the mode held before any same-cycle keyMode toggle.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        offset_d   = offset_q;
        timer_d    = timer_q;
        offset_sum = {1'b0, offset_q} + (OFF_W+1)'(DISP_W);

        if (state_q == SCAN) begin
            if (timer_q == SCAN_W'(SCAN_CYCLES - 1)) begin
                timer_d = '0;
                addr_d  = addr_q + 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
            if (press[0]) begin
                offset_d = (offset_sum >= (OFF_W+1)'(32)) ? '0 : offset_sum[OFF_W-1:0];
            end
        end else if (press[0]) begin
            addr_d = addr_q + 1'b1;
        end

        if (press[1]) begin
            state_d = (state_q == SCAN) ? MANUAL : SCAN;
            if (state_q == MANUAL) begin
                timer_d = '0;
            end
        end

        scan_mode_d = (state_d == SCAN);
        data_ext    = {{DISP_W{1'b0}}, regData};
        led_d       = {DISP_W'(data_ext >> offset_q), heartbeat};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            level_q     <= '0;
            state_q     <= MANUAL;
            addr_q      <= '0;
            offset_q    <= '0;
            timer_q     <= '0;
            led_q       <= '0;
            scan_mode_q <= 1'b0;
`ifdef BOARD_REG_VIEWER_DEBOUNCE_EN
            db_cnt_q    <= '0;
`endif
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            level_q     <= level_d;
            state_q     <= state_d;
            addr_q      <= addr_d;
            offset_q    <= offset_d;
            timer_q     <= timer_d;
            led_q       <= led_d;
            scan_mode_q <= scan_mode_d;
`ifdef BOARD_REG_VIEWER_DEBOUNCE_EN
            db_cnt_q    <= db_cnt_d;
`endif
        end
    end

    assign regAddr  = addr_q;
    assign led      = led_q;
    assign scanMode = scan_mode_q;

endmodule

// File: tb/tb_board_reg_viewer.sv
// Directed self-checking bench for board_reg_viewer (DEBOUNCE_CYCLES=4, SCAN_CYCLES=8, LED_WIDTH=8).
// Expected key latency and bounce behaviour follow BOARD_REG_VIEWER_DEBOUNCE_EN.
module tb_board_reg_viewer;

`ifdef BOARD_REG_VIEWER_DEBOUNCE_EN
    localparam int KEY_LAT      = 2 + 4;
    localparam int BOUNCE_STEPS = 0;
`else
    localparam int KEY_LAT      = 2;
    localparam int BOUNCE_STEPS = 2;
`endif

    logic        clock;
    logic        reset;
    logic        keyNext;
    logic        keyMode;
    logic        heartbeat;
    logic [31:0] regData;
    logic [4:0]  regAddr;
    logic [7:0]  led;
    logic        scanMode;

    int errorCount = 0;
    int checkCount = 0;

    board_reg_viewer #(
        .LED_WIDTH      (8),
        .REG_ADDR_W     (5),
        .DEBOUNCE_CYCLES(4),
        .SCAN_CYCLES    (8)
    ) dut (
        .clk      (clock),
        .rst      (reset),
        .keyNext  (keyNext),
        .keyMode  (keyMode),
        .heartbeat(heartbeat),
        .regData  (regData),
        .regAddr  (regAddr),
        .led      (led),
        .scanMode (scanMode)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // All driving and sampling happens on the falling edge, away from the active edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic applyStimulus(input logic nextLvl, input logic modeLvl, input int cycles);
        keyNext = nextLvl;
        keyMode = modeLvl;
        tick(cycles);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Window values of 0x89ABCDEF at offsets 7, 14, 21, 28, then back to 0.
    logic [6:0] windowExp [5] = '{7'h1B, 7'h2F, 7'h4D, 7'h08, 7'h6F};

    initial begin
        reset     = 1'b0;
        keyNext   = 1'b0;
        keyMode   = 1'b0;
        heartbeat = 1'b0;
        regData   = 32'hFFFF_FFFF;
        tick(2);

        // Reset state, then first display update with heartbeat low.
        reset = 1'b1;
        tick(1);
        checkOutput("reset_addr", 32'(regAddr), 32'd0);
        checkOutput("reset_scan", 32'(scanMode), 32'd0);
        checkOutput("reset_led", 32'(led), 32'd0);
        reset = 1'b0;
        tick(1);
        checkOutput("post_reset_led", 32'(led), 32'hFE);

        // First manual step: exact key latency.
        keyNext = 1'b1;
        tick(KEY_LAT);
        checkOutput("latency_before", 32'(regAddr), 32'd0);
        tick(1);
        checkOutput("latency_step", 32'(regAddr), 32'd1);
        tick(10 - KEY_LAT - 1);
        applyStimulus(1'b0, 1'b0, 10);

        // Remaining manual steps up to the wrap back to 0.
        for (int i = 2; i <= 32; i++) begin
            applyStimulus(1'b1, 1'b0, 10);
            applyStimulus(1'b0, 1'b0, 10);
            checkOutput($sformatf("manual_step%0d", i), 32'(regAddr), 32'(i % 32));
        end

        // regData to led is one cycle.
        regData = 32'h1234_5678;
        tick(1);
        checkOutput("data_latency", 32'(led), 32'hF0);

        // Short bounce: rejected when debounced, two presses otherwise.
        applyStimulus(1'b1, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 12);
        checkOutput("bounce_addr", 32'(regAddr), 32'(BOUNCE_STEPS));

        // SCAN entry and address dwell.
        keyMode = 1'b1;
        tick(KEY_LAT);
        checkOutput("scan_before", 32'(scanMode), 32'd0);
        tick(1);
        checkOutput("scan_entered", 32'(scanMode), 32'd1);
        tick(7);
        checkOutput("scan_dwell", 32'(regAddr), 32'(BOUNCE_STEPS));
        tick(1);
        checkOutput("scan_inc1", 32'(regAddr), 32'(BOUNCE_STEPS + 1));
        tick(8);
        checkOutput("scan_inc2", 32'(regAddr), 32'(BOUNCE_STEPS + 2));
        applyStimulus(1'b0, 1'b0, 10);

        // Window at offset 0, then one advance.
        regData   = 32'h89AB_CDEF;
        heartbeat = 1'b1;
        tick(2);
        checkOutput("window_0", 32'(led), 32'hDF);
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("window_7", 32'(led[7:1]), 32'h1B);

        // Back to MANUAL: offset retained, keyNext no longer moves it.
        applyStimulus(1'b0, 1'b1, 10);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("manual_again", 32'(scanMode), 32'd0);
        checkOutput("offset_kept", 32'(led[7:1]), 32'h1B);
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("offset_frozen", 32'(led[7:1]), 32'h1B);

        // Reset clears the offset as well.
        reset = 1'b1;
        tick(1);
        checkOutput("reset2_addr", 32'(regAddr), 32'd0);
        reset = 1'b0;
        tick(1);
        checkOutput("reset2_led", 32'(led), 32'hDF);

        // Simultaneous presses in MANUAL: step with old mode, then enter SCAN.
        keyNext = 1'b1;
        keyMode = 1'b1;
        tick(KEY_LAT + 1);
        checkOutput("simul_addr", 32'(regAddr), 32'd1);
        checkOutput("simul_scan", 32'(scanMode), 32'd1);
        checkOutput("simul_offset", 32'(led[7:1]), 32'h6F);
        keyNext = 1'b0;
        keyMode = 1'b0;
        tick(5);
        checkOutput("timer5_addr", 32'(regAddr), 32'd1);

        // Reset at scan-timer count 5.
        reset = 1'b1;
        tick(1);
        checkOutput("midscan_addr", 32'(regAddr), 32'd0);
        checkOutput("midscan_scan", 32'(scanMode), 32'd0);
        checkOutput("midscan_led", 32'(led), 32'd0);
        reset = 1'b0;
        tick(1);
        checkOutput("midscan_after", 32'(led), 32'hDF);
        tick(10);
        checkOutput("midscan_idle", 32'(regAddr), 32'd0);

        // Full window walk in SCAN.
        applyStimulus(1'b0, 1'b1, 10);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("scan_again", 32'(scanMode), 32'd1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 10);
            applyStimulus(1'b0, 1'b0, 10);
            checkOutput($sformatf("window_walk%0d", i), 32'(led[7:1]), 32'(windowExp[i]));
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
